// File: rtl/v810_mem_pkg.sv
// Shared types and codes for the V810 bus interface unit: cycle states,
// bus status codes and access-size decoding.
package v810_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T1H,
    S_T2H
  } state_t;

  localparam logic [1:0] ST_FETCH = 2'b10;

  localparam logic [1:0] BC_BYTE = 2'd0;
  localparam logic [1:0] BC_HALF = 2'd1;
  localparam logic [1:0] BC_WORD = 2'd2;

  // Right-justified read data is zero-filled above the access size.
  function automatic logic [31:0] size_mask(input logic [1:0] bc);
    case (bc)
      BC_BYTE: return 32'h0000_00FF;
      BC_HALF: return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/v810_mem_unit.sv
// V810 bus interface unit: arbitrates fetch/data requests onto one bus cycle
// engine with wait states and dynamic sizing to 16-bit devices.
module v810_mem_unit
  import v810_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] EUDA,
  input  logic [31:0] EUDD_O,
  output logic [31:0] EUDD_I,
  input  logic [1:0]  EUDBC,
  input  logic [3:0]  EUDBE,
  input  logic        EUDWR,
  input  logic        EUDMRQ,
  input  logic [1:0]  EUDST,
  input  logic        EUDREQ,
  output logic        EUDACK,
  input  logic [31:0] EUIA,
  output logic [31:0] EUID,
  input  logic        EUIREQ,
  output logic        EUIACK,
  output logic [31:0] A,
  input  logic [31:0] D_I,
  output logic [31:0] D_O,
  output logic [3:0]  BEn,
  output logic [1:0]  ST,
  output logic        DAn,
  output logic        MRQn,
  output logic        RW,
  output logic        BCYSTn,
  input  logic        READYn,
  input  logic        SZRQn
);

  state_t      r_state, w_state_next;
  logic [31:0] r_a, w_a_next;
  logic [31:0] r_do, w_do_next;
  logic [3:0]  r_ben, w_ben_next;
  logic [1:0]  r_st, w_st_next;
  logic        r_dan, w_dan_next;
  logic        r_mrqn, w_mrqn_next;
  logic        r_rw, w_rw_next;
  logic        r_bcystn, w_bcystn_next;
  logic        r_dack, w_dack_next;
  logic        r_iack, w_iack_next;
  logic [31:0] r_dd, w_dd_next;
  logic [31:0] r_id, w_id_next;
  logic [31:0] r_rdata, w_rdata_next;
  logic        r_fetch, w_fetch_next;
  logic [3:0]  r_be, w_be_next;
  logic [1:0]  r_off, w_off_next;
  logic [1:0]  r_bc, w_bc_next;

  logic [31:0] w_cap32;
  logic [31:0] w_cap;
  logic [31:0] w_wdata;
  logic        w_unused_ia;

  assign w_unused_ia = &{1'b0, EUIA[1:0]};
  assign w_wdata     = EUDD_O << {EUDA[1:0], 3'b000};

  // Full-width capture keeps lanes that are not enabled this beat.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_cap32[8*gi +: 8] = r_ben[gi] ? r_rdata[8*gi +: 8] : D_I[8*gi +: 8];
    end
  endgenerate

  assign w_cap = !SZRQn ? (r_a[1] ? {D_I[15:0], r_rdata[15:0]} : {r_rdata[31:16], D_I[15:0]})
                        : w_cap32;

  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_do_next     = r_do;
    w_ben_next    = r_ben;
    w_st_next     = r_st;
    w_dan_next    = r_dan;
    w_mrqn_next   = r_mrqn;
    w_rw_next     = r_rw;
    w_bcystn_next = r_bcystn;
    w_dack_next   = 1'b0;
    w_iack_next   = 1'b0;
    w_dd_next     = r_dd;
    w_id_next     = r_id;
    w_rdata_next  = r_rdata;
    w_fetch_next  = r_fetch;
    w_be_next     = r_be;
    w_off_next    = r_off;
    w_bc_next     = r_bc;
    case (r_state)
      S_IDLE: begin
        // The ACK cycle gives the requester one edge to drop its request.
        if (!r_dack && !r_iack) begin
          if (EUDREQ) begin
            w_fetch_next  = 1'b0;
            w_be_next     = EUDBE;
            w_off_next    = EUDA[1:0];
            w_bc_next     = EUDBC;
            w_a_next      = EUDA;
            w_ben_next    = ~EUDBE;
            w_rw_next     = ~EUDWR;
            w_mrqn_next   = ~EUDMRQ;
            w_st_next     = EUDST;
            w_do_next     = w_wdata;
            if (EUDWR && EUDA[1]) w_do_next[15:0] = w_wdata[31:16];
            w_rdata_next  = '0;
            w_bcystn_next = 1'b0;
            w_dan_next    = 1'b1;
            w_state_next  = S_T1;
          end else if (EUIREQ) begin
            w_fetch_next  = 1'b1;
            w_be_next     = 4'b1111;
            w_off_next    = 2'b00;
            w_bc_next     = BC_WORD;
            w_a_next      = {EUIA[31:2], 2'b00};
            w_ben_next    = 4'b0000;
            w_rw_next     = 1'b1;
            w_mrqn_next   = 1'b0;
            w_st_next     = ST_FETCH;
            w_rdata_next  = '0;
            w_bcystn_next = 1'b0;
            w_dan_next    = 1'b1;
            w_state_next  = S_T1;
          end
        end
      end
      S_T1, S_T1H: begin
        w_bcystn_next = 1'b1;
        w_dan_next    = 1'b0;
        w_state_next  = (r_state == S_T1) ? S_T2 : S_T2H;
      end
      S_T2, S_T2H: begin
        if (!READYn) begin
          w_rdata_next = w_cap;
          if (!SZRQn && r_state == S_T2 && |r_be[1:0] && |r_be[3:2]) begin
            w_a_next[1]     = 1'b1;
            w_ben_next      = {~r_be[3:2], 2'b11};
            w_do_next[15:0] = r_do[31:16];
            w_bcystn_next   = 1'b0;
            w_dan_next      = 1'b1;
            w_state_next    = S_T1H;
          end else begin
            w_ben_next    = 4'b1111;
            w_mrqn_next   = 1'b1;
            w_rw_next     = 1'b1;
            w_dan_next    = 1'b1;
            w_bcystn_next = 1'b1;
            w_state_next  = S_IDLE;
            if (r_fetch) begin
              w_iack_next = 1'b1;
              w_id_next   = w_cap;
            end else begin
              w_dack_next = 1'b1;
              w_dd_next   = (w_cap >> {r_off, 3'b000}) & size_mask(r_bc);
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_do     <= '0;
      r_ben    <= 4'b1111;
      r_st     <= 2'b00;
      r_dan    <= 1'b1;
      r_mrqn   <= 1'b1;
      r_rw     <= 1'b1;
      r_bcystn <= 1'b1;
      r_dack   <= 1'b0;
      r_iack   <= 1'b0;
      r_dd     <= '0;
      r_id     <= '0;
      r_rdata  <= '0;
      r_fetch  <= 1'b0;
      r_be     <= '0;
      r_off    <= '0;
      r_bc     <= '0;
    end else if (CE) begin
      r_state  <= w_state_next;
      r_a      <= w_a_next;
      r_do     <= w_do_next;
      r_ben    <= w_ben_next;
      r_st     <= w_st_next;
      r_dan    <= w_dan_next;
      r_mrqn   <= w_mrqn_next;
      r_rw     <= w_rw_next;
      r_bcystn <= w_bcystn_next;
      r_dack   <= w_dack_next;
      r_iack   <= w_iack_next;
      r_dd     <= w_dd_next;
      r_id     <= w_id_next;
      r_rdata  <= w_rdata_next;
      r_fetch  <= w_fetch_next;
      r_be     <= w_be_next;
      r_off    <= w_off_next;
      r_bc     <= w_bc_next;
    end
  end

  assign A      = r_a;
  assign D_O    = r_do;
  assign BEn    = r_ben;
  assign ST     = r_st;
  assign DAn    = r_dan;
  assign MRQn   = r_mrqn;
  assign RW     = r_rw;
  assign BCYSTn = r_bcystn;
  assign EUDACK = r_dack;
  assign EUIACK = r_iack;
  assign EUDD_I = r_dd;
  assign EUID   = r_id;

endmodule

// File: tb/tb_v810_mem_unit.sv
// Directed bench for v810_mem_unit: fetches, sized writes, wait states,
// 16-bit splitting, arbitration, clock enable and mid-cycle reset.
module tb_v810_mem_unit;

  logic        CLK = 1'b0;
  logic        RES, CE;
  logic [31:0] EUDA, EUDD_O, EUDD_I, EUIA, EUID, A, D_I, D_O;
  logic [1:0]  EUDBC, EUDST, ST;
  logic [3:0]  EUDBE, BEn;
  logic        EUDWR, EUDMRQ, EUDREQ, EUDACK, EUIREQ, EUIACK;
  logic        DAn, MRQn, RW, BCYSTn, READYn, SZRQn;

  int errors = 0;
  int checks = 0;

  v810_mem_unit dut (
    .CLK(CLK), .RES(RES), .CE(CE),
    .EUDA(EUDA), .EUDD_O(EUDD_O), .EUDD_I(EUDD_I), .EUDBC(EUDBC), .EUDBE(EUDBE),
    .EUDWR(EUDWR), .EUDMRQ(EUDMRQ), .EUDST(EUDST), .EUDREQ(EUDREQ), .EUDACK(EUDACK),
    .EUIA(EUIA), .EUID(EUID), .EUIREQ(EUIREQ), .EUIACK(EUIACK),
    .A(A), .D_I(D_I), .D_O(D_O), .BEn(BEn), .ST(ST), .DAn(DAn), .MRQn(MRQn),
    .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn), .SZRQn(SZRQn)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  int ndack, niack, data_first, acked;

  initial begin
    RES = 1'b1; CE = 1'b1;
    EUDA = '0; EUDD_O = '0; EUDBC = 2'd2; EUDBE = 4'hF; EUDWR = 1'b0;
    EUDMRQ = 1'b1; EUDST = 2'b00; EUDREQ = 1'b0;
    EUIA = '0; EUIREQ = 1'b0; D_I = '0; READYn = 1'b0; SZRQn = 1'b1;
    step(); step();
    chk("rst_A", A, 32'h0);
    chk("rst_DO", D_O, 32'h0);
    chk("rst_BEn", {28'h0, BEn}, 32'hF);
    chk("rst_ctl", {26'h0, ST, DAn, MRQn, RW, BCYSTn}, 32'h0000_000F);
    chk("rst_ack", {30'h0, EUDACK, EUIACK}, 32'h0);
    RES = 1'b0;

    // Fetch from 32-bit RAM, with a CE=0 freeze inside T1
    EUIA = 32'h0000_0004; D_I = 32'h1234_5678; EUIREQ = 1'b1;
    step();
    chk("f32_t1_A", A, 32'h0000_0004);
    chk("f32_t1_ctl", {24'h0, BEn, ST, MRQn, RW}, {24'h0, 4'b0000, 2'b10, 1'b0, 1'b1});
    chk("f32_t1_bcy", {30'h0, BCYSTn, DAn}, 32'h1);
    CE = 1'b0;
    step();
    chk("ce_freeze", {30'h0, BCYSTn, DAn}, 32'h1);
    CE = 1'b1;
    step();
    chk("f32_t2", {30'h0, BCYSTn, DAn}, 32'h2);
    step();
    chk("f32_ack", {30'h0, EUIACK, EUDACK}, 32'h2);
    chk("f32_EUID", EUID, 32'h1234_5678);
    chk("f32_idle", {24'h0, BEn, MRQn, DAn, RW, BCYSTn}, 32'h0000_00FF);
    EUIREQ = 1'b0;
    step();
    chk("f32_pulse", {30'h0, EUIACK, BCYSTn}, 32'h1);

    // Fetch from 16-bit ROM: two bus cycles
    EUIA = 32'hFFF0_0000; D_I = 32'hAAAA_5678; SZRQn = 1'b0; EUIREQ = 1'b1;
    step();
    chk("f16_A0", A, 32'hFFF0_0000);
    step();
    step();
    chk("f16_A1", A, 32'hFFF0_0002);
    chk("f16_h_ctl", {26'h0, BEn, BCYSTn, DAn}, {26'h0, 4'b0011, 1'b0, 1'b1});
    D_I = 32'hBBBB_1234;
    step();
    chk("f16_t2h_DAn", {31'h0, DAn}, 32'h0);
    step();
    chk("f16_ack", {31'h0, EUIACK}, 32'h1);
    chk("f16_EUID", EUID, 32'h1234_5678);
    EUIREQ = 1'b0; SZRQn = 1'b1;
    step();

    // Byte write to lane 3
    EUDA = 32'h0000_0003; EUDD_O = 32'h0000_00AB; EUDBE = 4'b1000; EUDBC = 2'd0;
    EUDWR = 1'b1; EUDMRQ = 1'b1; EUDST = 2'b01; EUDREQ = 1'b1;
    step();
    chk("bw_BEn", {28'h0, BEn}, 32'h7);
    chk("bw_DO_hi", {24'h0, D_O[31:24]}, 32'h0000_00AB);
    chk("bw_ctl", {28'h0, RW, MRQn, ST}, 32'h1);
    chk("bw_A", A, 32'h0000_0003);
    step();
    step();
    chk("bw_ack", {30'h0, EUDACK, EUIACK}, 32'h2);
    EUDREQ = 1'b0; EUDWR = 1'b0;
    step();
    chk("bw_pulse", {31'h0, EUDACK}, 32'h0);

    // Word read with three wait states
    EUDA = 32'h0000_0100; EUDBE = 4'hF; EUDBC = 2'd2; EUDST = 2'b00;
    D_I = 32'hCAFE_F00D; READYn = 1'b1; EUDREQ = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ws_DAn%0d", i), {30'h0, DAn, EUDACK}, 32'h0);
      if (i == 3) READYn = 1'b0;
    end
    step();
    chk("ws_ack", {30'h0, EUDACK, DAn}, 32'h3);
    chk("ws_data", EUDD_I, 32'hCAFE_F00D);
    EUDREQ = 1'b0;
    step();

    // Halfword read at offset 2: shifted down and zero-filled
    EUDA = 32'h0000_0202; EUDBE = 4'b1100; EUDBC = 2'd1; D_I = 32'h9ABC_5555;
    EUDREQ = 1'b1;
    acked = 0;
    for (int c = 0; c < 10 && acked == 0; c++) begin
      step();
      if (EUDACK) acked = 1;
    end
    chk("hr_ack_seen", acked, 1);
    chk("hr_data", EUDD_I, 32'h0000_9ABC);
    EUDREQ = 1'b0;
    step();

    // Simultaneous data and fetch requests
    EUDA = 32'h0000_0010; EUDBE = 4'hF; EUDBC = 2'd2; EUIA = 32'h0000_0020;
    D_I = 32'h1111_2222; EUDREQ = 1'b1; EUIREQ = 1'b1;
    ndack = 0; niack = 0; data_first = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (EUDACK) begin
        ndack++;
        if (niack == 0) data_first = 1;
        EUDREQ = 1'b0;
      end
      if (EUIACK) begin
        niack++;
        EUIREQ = 1'b0;
      end
    end
    chk("arb_order", data_first, 1);
    chk("arb_ndack", ndack, 1);
    chk("arb_niack", niack, 1);
    chk("arb_EUDD_I", EUDD_I, 32'h1111_2222);
    chk("arb_EUID", EUID, 32'h1111_2222);

    // Reset during T2, then restart of the held request
    EUDA = 32'h0000_0040; D_I = 32'h0BAD_BEEF; EUDREQ = 1'b1;
    step();
    step();
    chk("rs_inT2", {31'h0, DAn}, 32'h0);
    #2 RES = 1'b1;
    #1;
    chk("rs_ctl", {24'h0, BEn, DAn, MRQn, RW, BCYSTn}, 32'h0000_00FF);
    chk("rs_A", A, 32'h0);
    chk("rs_data", EUDD_I | EUID, 32'h0);
    chk("rs_ack", {30'h0, EUDACK, EUIACK}, 32'h0);
    step();
    RES = 1'b0;
    step();
    chk("rs_restart", {31'h0, BCYSTn}, 32'h0);
    chk("rs_restart_A", A, 32'h0000_0040);
    step();
    step();
    chk("rs_ack2", {31'h0, EUDACK}, 32'h1);
    chk("rs_data2", EUDD_I, 32'h0BAD_BEEF);
    EUDREQ = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/v810_mem_unit.md
# v810_mem_unit

Bus interface unit between the V810 execution unit and the external 32-bit system bus. It arbitrates instruction fetches and data accesses onto one bus cycle engine, drives the V810-style bus strobes and lane enables, inserts wait states, and performs dynamic bus sizing to 16-bit devices. It sits between `v810_exec` and the memory decode (ROM/RAM) in the machine top.

## Interface
- No parameters.
- `CLK` in 1: system clock.
- `RES` in 1: asynchronous, active-high reset.
- `CE` in 1: clock enable; state advances only on `CLK` edges with `CE`=1.
- `EUDA` in 32: data address. `EUDD_O` in 32: write data, right-justified. `EUDD_I` out 32: read data, right-justified.
- `EUDBC` in 2: access size (0 byte, 1 half, 2/3 word). `EUDBE` in 4: active-high lane enables. `EUDWR` in 1: 1 = write.
- `EUDMRQ` in 1: 1 = memory space, 0 = I/O. `EUDST` in 2: bus status for data cycle.
- `EUDREQ` in 1: data request (level). `EUDACK` out 1: one-cycle completion pulse.
- `EUIA` in 32: fetch address. `EUID` out 32: fetched word. `EUIREQ` in 1: fetch request (level). `EUIACK` out 1: one-cycle completion pulse.
- `A` out 32, `D_I` in 32, `D_O` out 32, `BEn` out 4 (active-low lanes), `ST` out 2, `DAn` out 1, `MRQn` out 1, `RW` out 1 (1 = read), `BCYSTn` out 1, `READYn` in 1, `SZRQn` in 1 (0 = 16-bit device).

## Operation
- States: IDLE, T1, T2, T1H, T2H.
- IDLE: if `EUDREQ`, start data cycle; else if `EUIREQ`, start fetch. Data has priority. Request fields are latched at start.
- Data cycle: `A`=`EUDA`, `BEn`=~`EUDBE`, `RW`=~`EUDWR`, `MRQn`=~`EUDMRQ`, `ST`=`EUDST`, `D_O`=`EUDD_O` << 8*`EUDA[1:0]`.
- Fetch: `A`={`EUIA[31:2]`,2'b00}, `BEn`=0000, `RW`=1, `MRQn`=0, `ST`=2'b10.
- T1: `BCYSTn`=0, `DAn`=1, then go to T2.
- T2: `DAn`=0; sample `READYn`/`SZRQn` each enabled edge; `READYn`=1 means stay in T2 (wait state).
- On `READYn`=0 with `SZRQn`=1: capture `D_I` on enabled lanes, complete.
- On `READYn`=0 with `SZRQn`=0: capture `D_I[15:0]` into the half selected by `A[1]`.
  - If both halves are enabled (lanes in [1:0] and [3:2]), go to T1H. T1H/T2H repeat T1/T2 with `A[1]`=1, `BEn`={2'b11 on unused side}, `D_O[15:0]`=upper half.
  - Otherwise complete.
- Any 16-bit-capable write cycle with `A[1]`=1 duplicates `D_O[31:16]` onto `D_O[15:0]`.
- Complete: pulse `EUDACK` or `EUIACK` for one enabled cycle and return to IDLE.
  - Read data is written to `EUDD_I` (>> 8*`EUDA[1:0]`, zero-filled) or `EUID`, and held until the next completion of the same kind.
- Bus signals are held stable from T1 through the final T2. In IDLE: `MRQn`=1, `BCYSTn`=1, `DAn`=1, `RW`=1, `BEn`=1111; `A`/`ST`/`D_O` hold their last values.
- Misaligned (lane-crossing beyond the word) accesses are unsupported; `EUDBE` is trusted.

## Timing
- Reset values: `A`=0, `D_O`=0, `BEn`=1111, `ST`=00, `DAn`=1, `MRQn`=1, `RW`=1, `BCYSTn`=1, `EUDACK`=0, `EUIACK`=0, `EUDD_I`=0, `EUID`=0, state IDLE.
- Zero-wait 32-bit access takes 2 enabled cycles (T1, T2); ACK is high in the cycle after the T2 sample.
- Each `READYn`=1 sample adds 1 cycle. A 16-bit split adds 2 cycles plus waits.
- A request must remain asserted until its ACK. A request still high after ACK starts a new cycle from IDLE the next enabled cycle.
- `EUDREQ` and `EUIREQ` rising together: data first, then fetch.
- `RES` mid-cycle: immediate return to reset values; the cycle is dropped with no ACK.
- `CE`=0 freezes all state and outputs.

## Structure
- Package `v810_mem_pkg`: state enum, `ST` codes (fetch = 2'b10), size codes for `EUDBC`.
- Single module; no sub-modules.

## Test plan
- Fetch from 32-bit RAM, `EUIA`=0x00000004, `D_I`=0x12345678, `READYn`=0 → `BCYSTn` low 1 cycle, `EUID`=0x12345678, one `EUIACK` pulse, 2 cycles.
- Fetch `EUIA`=0xFFF00000 from 16-bit ROM (`SZRQn`=0), returning 0x5678 then 0x1234 → two bus cycles (`A[1]`=0 then 1), `EUID`=0x12345678.
- Byte write `EUDA`=0x00000003, `EUDD_O`=0xAB, `EUDBE`=1000 → `BEn`=0111, `D_O[31:24]`=0xAB, `RW`=0, `EUDACK` pulse.
- Read with 3 cycles of `READYn`=1 → `DAn` low for 4 cycles; ACK only after `READYn`=0.
- `EUDREQ` and `EUIREQ` asserted together → data cycle completes first, then fetch; exactly one pulse each.
- Assert `RES` during T2 → all outputs at reset values immediately, no ACK; after release, a held request restarts with T1.
